// File: rtl/spi_memory_pkg.sv
// Shared definitions for the SPI-addressed byte memory: default sizes,
// control FSM state encoding and the read/write flag encoding.
package spi_memory_pkg;

  localparam int ADDR_WIDTH_DEF = 7;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE_ADDR   = 3'd0,
    LATCH       = 3'd1,
    READ_WAIT   = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_GET   = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_input_conditioner.sv
// Per-pin conditioner: two-flop synchronizer, debounce counter and
// single-cycle edge pulses aligned with the conditioned level change.
module spi_input_conditioner #(
  parameter int   DEBOUNCE_WAIT = 3,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic pos_o,
  output logic neg_o
);

  localparam int CW = (DEBOUNCE_WAIT < 2) ? 1 : $clog2(DEBOUNCE_WAIT + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, pos_q, neg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // The counter tracks how long the synchronized value has disagreed with
  // the conditioned level; any agreement restarts it.
  always_comb begin
    flip  = 1'b0;
    cnt_d = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_WAIT - 1)) flip = 1'b1;
      else                                 cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      level_q <= RESET_VAL;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_q ^ flip;
      pos_q   <= flip & ~level_q;
      neg_q   <= flip & level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign pos_o   = pos_q;
  assign neg_o   = neg_q;

endmodule

// File: rtl/spi_memory.sv
// SPI-slave 128x8 memory: conditioned pins feed a control FSM, shift register
// and synchronous RAM. Optional macro FAULT_INJECT_EN corrupts bit 0 on writes.
module spi_memory
  import spi_memory_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int DEBOUNCE_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_pin,
  input  logic                  cs_pin,
  input  logic                  mosi_pin,
  input  logic                  faultinjector_pin,
  output logic                  miso_pin,
  output logic [DATA_WIDTH-1:0] leds
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic sclk_lvl, sclk_pos, sclk_neg;
  logic cs_lvl, cs_pos, cs_neg;
  logic mosi_lvl, mosi_pos, mosi_neg;

  spi_input_conditioner #(.DEBOUNCE_WAIT(DEBOUNCE_WAIT), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .pin_i(sclk_pin),
    .level_o(sclk_lvl), .pos_o(sclk_pos), .neg_o(sclk_neg)
  );

  spi_input_conditioner #(.DEBOUNCE_WAIT(DEBOUNCE_WAIT), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .pin_i(cs_pin),
    .level_o(cs_lvl), .pos_o(cs_pos), .neg_o(cs_neg)
  );

  spi_input_conditioner #(.DEBOUNCE_WAIT(DEBOUNCE_WAIT), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .pin_i(mosi_pin),
    .level_o(mosi_lvl), .pos_o(mosi_pos), .neg_o(mosi_neg)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    miso_q;
  logic [DATA_WIDTH-1:0]   leds_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];
  logic                    sr_we, addr_we, mem_we, miso_en;

`ifdef FAULT_INJECT_EN
  assign wdata = sr_q ^ {{(DATA_WIDTH-1){1'b0}}, faultinjector_pin};
  logic unused_pins;
  assign unused_pins = ^{sclk_lvl, cs_pos, cs_neg, mosi_pos, mosi_neg};
`else
  assign wdata = sr_q;
  logic unused_pins;
  assign unused_pins = ^{sclk_lvl, cs_pos, cs_neg, mosi_pos, mosi_neg, faultinjector_pin};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_we   = 1'b0;
    addr_we = 1'b0;
    mem_we  = 1'b0;
    miso_en = 1'b0;
    unique case (state_q)
      IDLE_ADDR: begin
        if (sclk_pos) begin
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = LATCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LATCH: begin
        addr_we = 1'b1;
        state_d = (sr_q[0] == RW_READ) ? READ_WAIT : WRITE_GET;
      end
      READ_WAIT: state_d = READ_LOAD;
      READ_LOAD: begin
        sr_we   = 1'b1;
        state_d = READ_SHIFT;
      end
      READ_SHIFT: begin
        miso_en = 1'b1;
        if (sclk_pos) begin
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE_GET: begin
        if (sclk_pos) begin
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = WRITE_STORE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE_STORE: begin
        mem_we  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE_ADDR;
    endcase
    // Deselect overrides everything, so a partial frame never writes.
    if (cs_lvl) begin
      state_d = IDLE_ADDR;
      cnt_d   = '0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_ADDR;
      cnt_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      miso_q  <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sr_we)         sr_q <= rdata_q;
      else if (sclk_pos) sr_q <= {sr_q[DATA_WIDTH-2:0], mosi_lvl};
      if (addr_we)       addr_q <= sr_q[ADDR_WIDTH:1];
      if (sclk_neg && miso_en) miso_q <= sr_q[DATA_WIDTH-1];
      if (mem_we)        leds_q <= wdata;
    end
  end

  // Contents are deliberately not reset; read data lags the address by one cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= wdata;
    rdata_q <= mem_q[addr_q];
  end

  assign miso_pin = miso_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_spi_memory.sv
// Directed bench for spi_memory: table of write/read frames plus abort,
// glitch, mid-frame reset and (with FAULT_INJECT_EN) fault sequences.
module tb_spi_memory;
  import spi_memory_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_pin = 1'b0;
  logic       cs_pin = 1'b1;
  logic       mosi_pin = 1'b0;
  logic       faultinjector_pin = 1'b0;
  logic       miso_pin;
  logic [7:0] leds;

  int nchk = 0;
  int nerr = 0;

  spi_memory #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .DEBOUNCE_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_pin(mosi_pin), .faultinjector_pin(faultinjector_pin),
    .miso_pin(miso_pin), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] addr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk period of 10 clk; m is miso sampled mid high phase, i.e. the
  // bit presented by the previous falling edge.
  task automatic sclk_bit(input logic b, output logic m);
    mosi_pin = b;
    clks(2);
    sclk_pin = 1'b1;
    clks(3);
    m = miso_pin;
    clks(2);
    sclk_pin = 1'b0;
    clks(3);
  endtask

  // Full frame; glitch_at >= 0 inserts a 2-clk sclk pulse after that many address bits.
  task automatic frame(input logic [6:0] a, input logic rd, input logic [7:0] wd,
                       input int glitch_at, output logic [7:0] rdat);
    logic [7:0] hdr;
    logic       m;
    hdr = {a, rd};
    rdat = '0;
    cs_pin = 1'b0;
    clks(10);
    for (int i = 7; i >= 0; i--) begin
      if (glitch_at == 7 - i) begin
        sclk_pin = 1'b1;
        clks(2);
        sclk_pin = 1'b0;
        clks(10);
        chk("glitch_count", 32'(dut.cnt_q), 32'(glitch_at));
        chk("glitch_shift", 32'(dut.sr_q[2:0]), 32'(hdr[7:5]));
      end
      sclk_bit(hdr[i], m);
    end
    for (int i = 7; i >= 0; i--) begin
      sclk_bit(rd ? 1'b0 : wd[i], m);
      rdat[i] = m;
    end
    clks(10);
    cs_pin = 1'b1;
    clks(10);
  endtask

  vec_t       vecs [8];
  logic [7:0] rdat;
  logic [7:0] leds_exp;
  logic       m;

  initial begin
    vecs[0] = '{7'h55, 1'b0, 8'hCC, 8'hCC};
    vecs[1] = '{7'h55, 1'b1, 8'h00, 8'hCC};
    vecs[2] = '{7'h00, 1'b0, 8'h01, 8'h01};
    vecs[3] = '{7'h7F, 1'b0, 8'h80, 8'h80};
    vecs[4] = '{7'h00, 1'b1, 8'h00, 8'h01};
    vecs[5] = '{7'h7F, 1'b1, 8'h00, 8'h80};
    vecs[6] = '{7'h10, 1'b0, 8'h5A, 8'h5A};
    vecs[7] = '{7'h10, 1'b1, 8'h00, 8'h5A};

    clks(3);
    chk("reset_miso", 32'(miso_pin), 32'd0);
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(IDLE_ADDR));
    rst_n = 1'b1;
    clks(10);

    leds_exp = 8'h00;
    for (int v = 0; v < 8; v++) begin
      frame(vecs[v].addr, vecs[v].rd, vecs[v].wdata, -1, rdat);
      if (vecs[v].rd) begin
        chk($sformatf("read_%0d", v), 32'(rdat), 32'(vecs[v].exp));
      end else begin
        leds_exp = vecs[v].exp;
        chk($sformatf("write_leds_%0d", v), 32'(leds), 32'(leds_exp));
      end
    end

    // Abort a write to 0x10 after four data bits.
    cs_pin = 1'b0;
    clks(10);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] hdr;
      hdr = {7'h10, RW_WRITE};
      sclk_bit(hdr[i], m);
    end
    for (int i = 0; i < 4; i++) sclk_bit(1'b1, m);
    cs_pin = 1'b1;
    clks(20);
    chk("abort_leds", 32'(leds), 32'(leds_exp));
    chk("abort_state", 32'(dut.state_q), 32'(IDLE_ADDR));
    frame(7'h10, RW_READ, 8'h00, -1, rdat);
    chk("abort_mem", 32'(rdat), 32'h5A);

    // Glitch on sclk after three address bits must be filtered out.
    frame(7'h55, RW_READ, 8'h00, 3, rdat);
    chk("glitch_read", 32'(rdat), 32'hCC);

    // Reset in the middle of a read of 0x55 (MSB bits are 1).
    cs_pin = 1'b0;
    clks(10);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] hdr;
      hdr = {7'h55, RW_READ};
      sclk_bit(hdr[i], m);
    end
    sclk_bit(1'b0, m);
    sclk_bit(1'b0, m);
    chk("pre_reset_miso", 32'(miso_pin), 32'd1);
    rst_n = 1'b0;
    clks(2);
    chk("midreset_miso", 32'(miso_pin), 32'd0);
    chk("midreset_leds", 32'(leds), 32'd0);
    chk("midreset_state", 32'(dut.state_q), 32'(IDLE_ADDR));
    cs_pin = 1'b1;
    sclk_pin = 1'b0;
    mosi_pin = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(10);
    frame(7'h55, RW_READ, 8'h00, -1, rdat);
    chk("post_reset_read", 32'(rdat), 32'hCC);
    frame(7'h2A, RW_WRITE, 8'h3C, -1, rdat);
    chk("post_reset_leds", 32'(leds), 32'h3C);
    frame(7'h2A, RW_READ, 8'h00, -1, rdat);
    chk("post_reset_mem", 32'(rdat), 32'h3C);

`ifdef FAULT_INJECT_EN
    faultinjector_pin = 1'b1;
    frame(7'h01, RW_WRITE, 8'hCC, -1, rdat);
    faultinjector_pin = 1'b0;
    chk("fault_leds", 32'(leds), 32'hCD);
    frame(7'h01, RW_READ, 8'h00, -1, rdat);
    chk("fault_read", 32'(rdat), 32'hCD);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
